spi_slave_receiver: RTL

SPI slave endpoint that sits directly downstream of spi_generator and consumes its CS/SCK/MOSI, returning MISO.
- Oversamples all SPI inputs on the system clock CLK.
- Supports all four CKP/CPH modes, MSB first.
- Deserialises 8-bit words into a held output register with a valid/ack handshake.
- Serialises a parallel transmit word back on MISO.

---
 rtl/spi_slave_receiver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_receiver.sv
// -----------------------------------------------------------------------------
// spi_slave_receiver
//
// This is an SPI slave endpoint. CS, SCK and MOSI are oversampled on the system
// clock CLK. The block handles all four CKP/CPH modes and transfers data MSB
// first. It deserialises DATA_W-bit words into a held register, which the
// consumer takes through a valid/ack handshake. In the other direction it
// serialises tx_data back to the master on MISO. Words may run back to back
// while CS stays low.
//
// Ports
//   CLK        system clock; every flop updates on its rising edge
//   RESET      asynchronous, active-high reset
//   CKP        SCK idle level (must match the master)
//   CPH        0: sample on the leading edge; 1: sample on the trailing edge
//   CS         active-low chip select from the master
//   SCK        serial clock from the master
//   MOSI       serial data from the master
//   MISO       serial data to the master
//   tx_data    word to transmit; captured at frame start and at each word end
//   rx_data    last complete received word
//   rx_valid   rx_data holds an unacknowledged word
//   rx_ack     consumer accepts rx_data (single-cycle pulse)
//   overrun    sticky; a word completed while rx_valid was still pending
//   frame_err  single-cycle pulse; CS rose in the middle of a word
//   busy       high while a frame is active
// -----------------------------------------------------------------------------
module spi_slave_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d, sck_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_shift, tx_shift;
  logic                   word_done;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one extra stage each on CS and SCK for edge
  // detection.
  // NOTE: these flops reset to 0 on purpose. If CS is already low when RESET
  // releases, the synchronised CS never shows a falling edge, so the block
  // does not join a frame that is already in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every flop its previous-cycle
      // value, which is what makes this a shift chain and not a single wire.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  // A leading edge leaves the idle level. A trailing edge returns to it.
  assign lead_edge   = (sck_d == CKP) && (sck_s != CKP);
  assign trail_edge  = (sck_d != CKP) && (sck_s == CKP);
  assign sample_edge = CPH ? trail_edge : lead_edge;
  assign shift_edge  = CPH ? lead_edge  : trail_edge;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic start, stop, do_sample, do_shift, last_bit;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    start     = 1'b0;
    stop      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ACTIVE);

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      MISO      <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      word_done <= do_sample && last_bit;
      frame_err <= stop && (bit_cnt != '0);

      if (start) begin
        bit_cnt  <= '0;
        tx_shift <= tx_data;
        // With CPH=0 the master samples on the first leading edge, so the MSB
        // must already be on MISO at that point.
        if (!CPH) MISO <= tx_data[DATA_W-1];
      end else if (stop) begin
        bit_cnt <= '0;
        MISO    <= 1'b0;
      end else begin
        if (do_sample) begin
          rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
        end

        if (word_done) begin
          tx_shift <= tx_data;
        end else if (do_shift) begin
          if (CPH) begin
            MISO     <= tx_shift[DATA_W-1];
            tx_shift <= tx_shift << 1;
          end else if (bit_cnt == '0) begin
            // CPH=0 trailing edge of a word's last bit. The freshly reloaded
            // MSB goes out here and is not shifted yet.
            MISO <= tx_shift[DATA_W-1];
          end else begin
            // The MSB is already out, so drive the next bit and then shift.
            MISO     <= tx_shift[DATA_W-2];
            tx_shift <= tx_shift << 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive handshake. A completed word always lands in rx_data. Overrun is
  // flagged only when the previous word was neither taken before nor taken in
  // this same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (word_done) begin
      rx_data  <= rx_shift;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ack) overrun <= 1'b1;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
